key_expander: RTL and testbench
===============================

# key_expander

- Generates the AES key schedule one 32-bit word per transfer, from a cipher key supplied one word at a time.
- Sits directly upstream of the key schedule storage shift register.
  - `word_out` drives its `din`.
  - `word_valid & word_ready` drives its `new_in`/`shift` pair.
- Emits w[0]..w[4·(NR+1)−1] in ascending order, so the storage ends holding the full schedule with the last round key nearest `dout`.

## Interface
- `NK`, default 4: key length in 32-bit words.
  - Legal values: 4, 6, 8 (AES-128/192/256).
  - NR = NK+6.
  - TOTAL = 4·(NR+1) = 44/52/60.
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a new expansion. Sampled only in IDLE.
- `key_in`, in, 32: cipher key word. Byte 0 is in bits [0:7].
- `key_valid`, in, 1: `key_in` valid.
- `key_ready`, out, 1: expander accepts `key_in`.
- `word_out`, out, 32: schedule word w[i], bit order [0:31].
- `word_valid`, out, 1: `word_out` valid.
- `word_ready`, in, 1: downstream accepts `word_out`.
- `busy`, out, 1: high in LOAD and EXPAND.
- `done`, out, 1: one-cycle pulse after the final word transfer.

## Operation
- States:
  - IDLE: `start` → LOAD; clear i, set rcon = 8'h01.
  - LOAD: pass-through. `word_out = key_in`, `word_valid = key_valid`, `key_ready = word_ready`.
    - On each transfer: push the word into the window and increment i.
    - After NK transfers → EXPAND.
  - EXPAND: `word_out` is computed combinationally from the window, `word_valid = 1`, `key_ready = 0`.
    - On each transfer: push the word, increment i.
    - When i = TOTAL−1 transfers → IDLE and pulse `done`.
- Window: NK×32-bit register shift chain holding w[i−NK]..w[i−1].
- Word rule: temp = w[i−1].
  - If i mod NK = 0: temp = SubWord(RotWord(temp)) ^ {rcon, 24'h0}. RotWord{b0,b1,b2,b3} = {b1,b2,b3,b0}.
  - Else if NK = 8 and i mod NK = 4: temp = SubWord(temp).
  - w[i] = w[i−NK] ^ temp.
- rcon advances by xtime (GF(2^8), poly 0x11B) on every transfer where i mod NK = 0. Sequence: 01, 02, … 80, 1B, 36.
- Track i mod NK with a separate 3-bit counter; no divider.
- Stall: while `word_ready = 0`, state, i, rcon and window hold, and `word_out` stays stable.
- `start` while `busy` is ignored. `key_valid` outside LOAD is ignored.

## Timing
- Reset values: state IDLE, i = 0, rcon = 01, window = 0.
  - `key_ready`, `word_valid`, `busy`, `done` = 0.
  - `word_out` = 0 in IDLE.
- Latency: the key word appears on `word_out` in the same cycle it is presented (zero latency).
- First expanded word w[NK] is valid in the cycle after the NK-th key transfer.
- Unstalled throughput: 1 word/cycle. IDLE→done takes 1 + TOTAL cycles minimum.
- `done` is asserted in the cycle after the last transfer, concurrent with `busy` = 0.
- `start` may be accepted in the same cycle `done` is high.
- Reset mid-operation: outputs reach reset values immediately. A partial schedule is abandoned; the downstream storage is reset by its own reset.
- Critical path: window → S-box → XOR → `word_out`. No register is required on `word_out`.

## Structure
- Shared package `aes_pkg`:
  - 32-bit word type and the SBOX table constant.
  - xtime function and RCON_INIT.
  - `total_words(NK)` function.
- Sub-module `aes_sbox`: combinational byte S-box from `aes_pkg`, instantiated 4× for SubWord.
- All control (FSM, i counter, mod counter, rcon, window) lives in `key_expander`.

## Test plan
- NK=4, FIPS-197 A.1 key 2b7e1516 28aed2a6 abf71588 09cf4f3c, `word_ready` = 1:
  - w4 = a0fafe17, w43 = b6630ca6.
  - Exactly 44 transfers.
  - `done` pulses once, 45 cycles after `start`.
- NK=6, A.2 key 8e73b0f7 da0e6452 c810f32b 809079e5 62f8ead2 522c6b7b:
  - w6 = fe0c91f7, w51 = 01002202.
  - 52 transfers.
- NK=8, A.3 key 603deb10 15ca71be 2b73aef0 857d7781 1f352c07 3b6108d7 2d9810a3 0914dff4:
  - w8 = 9ba35411, w59 = 706c631e.
  - Covers the i mod 8 = 4 SubWord path.
- NK=4, stalls:
  - `word_ready` low for 3 cycles at i = 20, and `key_valid` gapped during LOAD.
  - `word_out` holds stable while stalled, with no skipped or duplicated words.
  - w43 is still b6630ca6.
- Pulse `start` at i = 10 → ignored, sequence unchanged.
- Assert `rst` low at i = 30 → `busy` = 0 and `word_valid` = 0 immediately.
  - A fresh `start` then reproduces the A.1 words from w0.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES definitions: word type, S-box table, GF(2^8) helpers and
// key-schedule sizing used by the key expander and its S-box lanes.
package aes_pkg;

  typedef logic [0:31] word_t;

  typedef enum logic [1:0] {
    KX_IDLE   = 2'd0,
    KX_LOAD   = 2'd1,
    KX_EXPAND = 2'd2
  } kx_state_t;

  localparam logic [7:0] RCON_INIT = 8'h01;

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // 4 words per round key, NR = NK + 6 rounds plus the initial key.
  function automatic int total_words(input int nk);
    return 4 * (nk + 7);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte lane.
module aes_sbox
  import aes_pkg::*;
(
  input  logic [7:0] din,
  output logic [7:0] dout
);

  assign dout = SBOX[din];

endmodule

// File: rtl/key_expander.sv
// AES key schedule generator: passes the NK key words through, then derives
// the remaining schedule words one per transfer from an NK-word window.
module key_expander
  import aes_pkg::*;
#(
  parameter int NK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [0:31] key_in,
  input  logic        key_valid,
  output logic        key_ready,
  output logic [0:31] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        busy,
  output logic        done
);

  localparam int TOTAL = total_words(NK);

  kx_state_t   state_reg;
  logic [5:0]  i_reg;
  logic [2:0]  mod_reg;
  logic [2:0]  mod_next;
  logic [7:0]  rcon_reg;
  logic        done_reg;
  word_t       window_reg [NK];

  word_t       prev_word;
  word_t       rot_word;
  word_t       sub_in;
  word_t       sub_out;
  word_t       temp_word;
  word_t       exp_word;
  logic        xfer;

  assign prev_word = window_reg[NK-1];
  assign rot_word  = {prev_word[8:31], prev_word[0:7]};
  assign sub_in    = (mod_reg == 3'd0) ? rot_word : prev_word;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .din  (sub_in[gi*8 +: 8]),
        .dout (sub_out[gi*8 +: 8])
      );
    end
  endgenerate

  always_comb begin
    temp_word = prev_word;
    if (mod_reg == 3'd0)
      temp_word = sub_out ^ {rcon_reg, 24'h000000};
    else if (NK == 8 && mod_reg == 3'd4)
      temp_word = sub_out;
  end

  assign exp_word = window_reg[0] ^ temp_word;

  // Handshake outputs follow the state register directly so an asynchronous
  // reset clears them without waiting for a clock edge.
  always_comb begin
    word_out   = '0;
    word_valid = 1'b0;
    key_ready  = 1'b0;
    case (state_reg)
      KX_LOAD: begin
        word_out   = key_in;
        word_valid = key_valid;
        key_ready  = word_ready;
      end
      KX_EXPAND: begin
        word_out   = exp_word;
        word_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign xfer     = word_valid & word_ready;
  assign busy     = (state_reg != KX_IDLE);
  assign done     = done_reg;
  assign mod_next = (mod_reg == 3'(NK - 1)) ? 3'd0 : mod_reg + 3'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= KX_IDLE;
      i_reg     <= '0;
      mod_reg   <= '0;
      rcon_reg  <= RCON_INIT;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        KX_IDLE: begin
          if (start) begin
            state_reg <= KX_LOAD;
            i_reg     <= '0;
            mod_reg   <= '0;
            rcon_reg  <= RCON_INIT;
          end
        end
        KX_LOAD: begin
          if (xfer) begin
            i_reg   <= i_reg + 6'd1;
            mod_reg <= mod_next;
            if (i_reg == 6'(NK - 1))
              state_reg <= KX_EXPAND;
          end
        end
        KX_EXPAND: begin
          if (xfer) begin
            i_reg   <= i_reg + 6'd1;
            mod_reg <= mod_next;
            if (mod_reg == 3'd0)
              rcon_reg <= xtime(rcon_reg);
            if (i_reg == 6'(TOTAL - 1)) begin
              state_reg <= KX_IDLE;
              done_reg  <= 1'b1;
            end
          end
        end
        default: state_reg <= KX_IDLE;
      endcase
    end
  end

  // Window slot NK-1 holds the newest word w[i-1], slot 0 the oldest w[i-NK].
  generate
    for (genvar gi = 0; gi < NK; gi++) begin : g_window
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)
          window_reg[gi] <= '0;
        else if (xfer) begin
          if (gi == NK - 1)
            window_reg[gi] <= word_out;
          else
            window_reg[gi] <= window_reg[(gi + 1) % NK];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_key_expander.sv
// Randomized self-checking bench for key_expander at NK = 4, 6 and 8 against
// a behavioural key-schedule model with an independently derived S-box.
module tb_key_expander;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_s      [3];
  logic [31:0] key_in_s     [3];
  logic        key_valid_s  [3];
  logic        key_ready_s  [3];
  logic [31:0] word_out_s   [3];
  logic        word_valid_s [3];
  logic        word_ready_s [3];
  logic        busy_s       [3];
  logic        done_s       [3];

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  ref_sbox [256];
  logic [31:0] cur_key  [8];
  logic [31:0] model_w  [60];
  logic [31:0] got_w    [60];

  always #5 clk = ~clk;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      key_expander #(.NK(4 + 2*gi)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start_s[gi]),
        .key_in     (key_in_s[gi]),
        .key_valid  (key_valid_s[gi]),
        .key_ready  (key_ready_s[gi]),
        .word_out   (word_out_s[gi]),
        .word_valid (word_valid_s[gi]),
        .word_ready (word_ready_s[gi]),
        .busy       (busy_s[gi]),
        .done       (done_s[gi])
      );
    end
  endgenerate

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a = a_in;
    logic [7:0] b = b_in;
    logic [7:0] p = 8'h00;
    for (int j = 0; j < 8; j++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box = affine transform of the multiplicative inverse in GF(2^8).
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] xb = 8'(x);
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(xb, 8'(y)) == 8'h01) inv = 8'(y);
      ref_sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {ref_sbox[w[31:24]], ref_sbox[w[23:16]], ref_sbox[w[15:8]], ref_sbox[w[7:0]]};
  endfunction

  task automatic build_model(input int nk);
    logic [7:0]  rc = 8'h01;
    logic [31:0] t;
    for (int i = 0; i < 60; i++) model_w[i] = '0;
    for (int i = 0; i < nk; i++) model_w[i] = cur_key[i];
    for (int i = nk; i < 4 * (nk + 7); i++) begin
      t = model_w[i-1];
      if (i % nk == 0) begin
        t  = subword({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end else if (nk == 8 && i % nk == 4) begin
        t = subword(t);
      end
      model_w[i] = model_w[i-nk] ^ t;
    end
  endtask

  task automatic idle_inputs(input int k);
    start_s[k]      = 1'b0;
    key_valid_s[k]  = 1'b0;
    key_in_s[k]     = '0;
    word_ready_s[k] = 1'b0;
  endtask

  // One expansion on instance k; returns early if a reset is injected.
  task automatic run_exp(input int k, input int stall_i, input bit gap,
                         input int start_i, input int rst_i, input bit clean);
    int nk = 4 + 2*k;
    int total = 4 * (nk + 7);
    int n = 0;
    int cyc;
    int stall_left = 3;
    logic exp_valid;
    logic rdy;
    build_model(nk);
    for (int i = 0; i < 60; i++) got_w[i] = 'x;
    @(negedge clk);
    start_s[k] = 1'b1;
    @(negedge clk);
    start_s[k] = 1'b0;
    cyc = 1;
    while (n < total) begin
      if (cyc > 600) begin
        check_eq("timeout_words", 32'(n), 32'(total));
        break;
      end
      rdy = 1'b1;
      if (n == stall_i && stall_left > 0) begin
        rdy = 1'b0;
        stall_left--;
      end
      word_ready_s[k] = rdy;
      if (n < nk) begin
        exp_valid = gap ? 1'($urandom_range(0, 1)) : 1'b1;
        key_valid_s[k] = exp_valid;
        key_in_s[k] = exp_valid ? cur_key[n] : $urandom;
      end else begin
        exp_valid = 1'b1;
        key_valid_s[k] = 1'($urandom_range(0, 1));
        key_in_s[k] = $urandom;
      end
      start_s[k] = (n == start_i);
      if (n == rst_i) begin
        rst = 1'b0;
        #2;
        check_eq("rst_busy", 32'(busy_s[k]), 32'd0);
        check_eq("rst_word_valid", 32'(word_valid_s[k]), 32'd0);
        check_eq("rst_key_ready", 32'(key_ready_s[k]), 32'd0);
        check_eq("rst_done", 32'(done_s[k]), 32'd0);
        check_eq("rst_word_out", word_out_s[k], 32'h0);
        @(negedge clk);
        idle_inputs(k);
        rst = 1'b1;
        $display("run nk=%0d aborted by reset at i=%0d", nk, n);
        return;
      end
      #2;
      check_eq($sformatf("word_valid_i%0d", n), 32'(word_valid_s[k]), 32'(exp_valid));
      check_eq($sformatf("key_ready_i%0d", n), 32'(key_ready_s[k]), (n < nk) ? 32'(rdy) : 32'd0);
      check_eq($sformatf("busy_i%0d", n), 32'(busy_s[k]), 32'd1);
      check_eq($sformatf("done_early_i%0d", n), 32'(done_s[k]), 32'd0);
      if (exp_valid)
        check_eq($sformatf("nk%0d_w%0d", nk, n), word_out_s[k], model_w[n]);
      if (exp_valid && rdy) begin
        got_w[n] = word_out_s[k];
        n++;
      end
      @(negedge clk);
      cyc++;
    end
    idle_inputs(k);
    #2;
    check_eq("done_pulse", 32'(done_s[k]), 32'd1);
    check_eq("busy_after", 32'(busy_s[k]), 32'd0);
    check_eq("idle_word_valid", 32'(word_valid_s[k]), 32'd0);
    check_eq("idle_word_out", word_out_s[k], 32'h0);
    if (clean) check_eq("done_latency", 32'(cyc), 32'(1 + total));
    @(negedge clk);
    #2;
    check_eq("done_single", 32'(done_s[k]), 32'd0);
    $display("run nk=%0d words=%0d cycles=%0d stall_at=%0d gap=%0d", nk, n, cyc, stall_i, gap);
  endtask

  initial begin
    for (int k = 0; k < 3; k++) idle_inputs(k);
    build_sbox();
    @(negedge clk);
    #2;
    for (int k = 0; k < 3; k++) begin
      check_eq("reset_busy", 32'(busy_s[k]), 32'd0);
      check_eq("reset_done", 32'(done_s[k]), 32'd0);
      check_eq("reset_word_valid", 32'(word_valid_s[k]), 32'd0);
      check_eq("reset_key_ready", 32'(key_ready_s[k]), 32'd0);
      check_eq("reset_word_out", word_out_s[k], 32'h0);
    end
    @(negedge clk);
    rst = 1'b1;

    cur_key = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 0, 0, 0, 0};
    run_exp(0, -1, 1'b0, -1, -1, 1'b1);
    check_eq("A1_w4", got_w[4], 32'ha0fafe17);
    check_eq("A1_w43", got_w[43], 32'hb6630ca6);

    cur_key = '{32'h8e73b0f7, 32'hda0e6452, 32'hc810f32b, 32'h809079e5,
                32'h62f8ead2, 32'h522c6b7b, 0, 0};
    run_exp(1, -1, 1'b0, -1, -1, 1'b1);
    check_eq("A2_w6", got_w[6], 32'hfe0c91f7);
    check_eq("A2_w51", got_w[51], 32'h01002202);

    cur_key = '{32'h603deb10, 32'h15ca71be, 32'h2b73aef0, 32'h857d7781,
                32'h1f352c07, 32'h3b6108d7, 32'h2d9810a3, 32'h0914dff4};
    run_exp(2, -1, 1'b0, -1, -1, 1'b1);
    check_eq("A3_w8", got_w[8], 32'h9ba35411);
    check_eq("A3_w59", got_w[59], 32'h706c631e);

    cur_key = '{32'h2b7e1516, 32'h28aed2a6, 32'habf71588, 32'h09cf4f3c, 0, 0, 0, 0};
    run_exp(0, 20, 1'b1, -1, -1, 1'b0);
    check_eq("stall_w43", got_w[43], 32'hb6630ca6);

    run_exp(0, -1, 1'b0, 10, -1, 1'b1);
    check_eq("start_ignored_w43", got_w[43], 32'hb6630ca6);

    run_exp(0, -1, 1'b0, -1, 30, 1'b0);
    run_exp(0, -1, 1'b0, -1, -1, 1'b1);
    check_eq("after_rst_w0", got_w[0], 32'h2b7e1516);
    check_eq("after_rst_w4", got_w[4], 32'ha0fafe17);
    check_eq("after_rst_w43", got_w[43], 32'hb6630ca6);

    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        for (int j = 0; j < 8; j++) cur_key[j] = $urandom;
        run_exp(k, $urandom_range(0, 4 * (4 + 2*k + 7) - 1), 1'b1, -1, -1, 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
